// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative radix-2 multiply/divide unit.
// Results land in HI/LO DATA_W+1 edges after a mul/div is accepted.
module hilo_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int W = DATA_W;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     d_q, d_d;
  logic [W-1:0]     a_q, a_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             done_q, done_d;

  logic         accept;
  logic         sgn_op, is_mul, is_dv, is_mthi, is_mtlo;
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic [W:0]   mul_sum;
  logic [W:0]   rem_s, diff;
  logic [2*W-1:0] mul_next, div_next, prod;
  logic [W-1:0] quo_f, rem_f;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    accept  = start && !flush && (state_q == IDLE);
    is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    is_dv   = (op == OP_DIV) || (op == OP_DIVU);
    is_mthi = (op == OP_MTHI);
    is_mtlo = (op == OP_MTLO);
    sgn_op  = (op == OP_MULT) || (op == OP_DIV);
    a_neg   = sgn_op && a[W-1];
    b_neg   = sgn_op && b[W-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;

    // shift-add: add multiplicand into the upper half, then shift right
    mul_sum  = {1'b0, acc_q[2*W-1:W]}
             + {1'b0, (acc_q[0] ? d_q : {W{1'b0}})};
    mul_next = {mul_sum, acc_q[W-1:1]};

    // restoring divide: acc holds {remainder, dividend/quotient}
    rem_s    = acc_q[2*W-1:W-1];
    diff     = rem_s - {1'b0, d_q};
    div_next = diff[W]
             ? {rem_s[W-1:0], acc_q[W-2:0], 1'b0}
             : {diff[W-1:0], acc_q[W-2:0], 1'b1};

    prod  = neg_res_q ? -acc_q : acc_q;
    quo_f = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_f = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    d_d       = d_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul: begin
              d_d       = a_mag;
              acc_d     = {{W{1'b0}}, b_mag};
              is_div_d  = 1'b0;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              cnt_d     = '0;
              state_d   = CALC;
            end
            is_dv: begin
              d_d       = b_mag;
              acc_d     = {{W{1'b0}}, a_mag};
              a_d       = a;
              is_div_d  = 1'b1;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              cnt_d     = '0;
              state_d   = CALC;
            end
            is_mthi: hi_d = a;
            is_mtlo: lo_d = a;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[2*W-1:W];
            lo_d = prod[W-1:0];
          end else if (d_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_f;
            lo_d = quo_f;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      d_q       <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      d_q       <= d_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: latency, signed/unsigned results,
// divide-by-zero, MTHI/MTLO, flush, reset and busy handling.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  hilo_muldiv #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present a request, take it through one edge, drop start.
  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (bounded) and busy samples on the way.
  task automatic wait_done(output int n, output int bz);
    n  = 0;
    bz = busy ? 1 : 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy) bz++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
  endtask

  task automatic test_mult;
    int n, bz;
    issue(3'b001, 32'hFFFF_FFFD, 32'd5);
    total++; if (busy !== 1'b1) $display("FAIL mult_busy_t0 got %b want 1", busy); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL mult_hi_stable got %h want 0", hi); else passed++;
    wait_done(n, bz);
    total++; if (n !== 33) $display("FAIL mult_latency got %0d want 33", n); else passed++;
    total++; if (bz !== 33) $display("FAIL mult_busy_cycles got %0d want 33", bz); else passed++;
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", hi); else passed++;
    total++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_lo got %h want fffffff1", lo); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0) $display("FAIL mult_done_width got %b want 0", done); else passed++;
  endtask

  task automatic test_multu_b2b;
    int n, bz;
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, bz);
    total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", hi); else passed++;
    total++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", lo); else passed++;
    issue(3'b100, 32'd100, 32'd7);
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept got %b want 1", busy); else passed++;
    wait_done(n, bz);
    total++; if (n !== 33) $display("FAIL divu_latency got %0d want 33", n); else passed++;
    total++; if (lo !== 32'h0000_000E) $display("FAIL divu_lo got %h want 0000000e", lo); else passed++;
    total++; if (hi !== 32'h0000_0002) $display("FAIL divu_hi got %h want 00000002", hi); else passed++;
  endtask

  task automatic test_div;
    int n, bz;
    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, bz);
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo got %h want fffffffd", lo); else passed++;
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi got %h want ffffffff", hi); else passed++;
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bz);
    total++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo got %h want 80000000", lo); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL div_ovf_hi got %h want 0", hi); else passed++;
  endtask

  task automatic test_div_zero;
    int n, bz;
    issue(3'b100, 32'h0000_1234, 32'h0);
    wait_done(n, bz);
    total++; if (n !== 33) $display("FAIL divu0_latency got %0d want 33", n); else passed++;
    total++; if (hi !== 32'h0000_1234) $display("FAIL divu0_hi got %h want 00001234", hi); else passed++;
    total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu0_lo got %h want ffffffff", lo); else passed++;
    issue(3'b000, 32'h0, 32'h0);
    issue(3'b011, 32'h0000_1234, 32'h0);
    wait_done(n, bz);
    total++; if (n !== 33) $display("FAIL div0_latency got %0d want 33", n); else passed++;
    total++; if (hi !== 32'h0000_1234) $display("FAIL div0_hi got %h want 00001234", hi); else passed++;
    total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL div0_lo got %h want ffffffff", lo); else passed++;
  endtask

  task automatic test_mthi_mtlo;
    issue(3'b000, 32'hDEAD_BEEF, 32'h0);
    total++; if (busy !== 1'b0) $display("FAIL opnone_busy got %b want 0", busy); else passed++;
    total++; if (hi !== 32'h0000_1234) $display("FAIL opnone_hi got %h want 00001234", hi); else passed++;
    op = 3'b101; a = 32'hCAFE_F00D; start = 1'b1;
    @(posedge clk); #1;
    total++; if (hi !== 32'hCAFE_F00D) $display("FAIL mthi_hi got %h want cafef00d", hi); else passed++;
    total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL mthi_lo got %h want ffffffff", lo); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mthi_busy got %b want 0", busy); else passed++;
    op = 3'b110; a = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (lo !== 32'h1234_5678) $display("FAIL mtlo_lo got %h want 12345678", lo); else passed++;
    total++; if (hi !== 32'hCAFE_F00D) $display("FAIL mtlo_hi got %h want cafef00d", hi); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mtlo_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL mtlo_done got %b want 0", done); else passed++;
    flush = 1'b1;
    issue(3'b001, 32'd3, 32'd3);
    flush = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL idle_flush_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_flush;
    int seen;
    issue(3'b001, 32'd1000, 32'd1000);
    repeat (9) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) $display("FAIL flush_pre_busy got %b want 1", busy); else passed++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else passed++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 0) $display("FAIL flush_done got %0d pulses want 0", seen); else passed++;
    total++; if (hi !== 32'hCAFE_F00D) $display("FAIL flush_hi got %h want cafef00d", hi); else passed++;
    total++; if (lo !== 32'h1234_5678) $display("FAIL flush_lo got %h want 12345678", lo); else passed++;
  endtask

  task automatic test_start_while_busy;
    int n, bz;
    op = 3'b001; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd7; b = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL held_busy got %b want 1", busy); else passed++;
    wait_done(n, bz);
    total++; if (n + 5 !== 33) $display("FAIL held_latency got %0d want 33", n + 5); else passed++;
    total++; if (lo !== 32'd6) $display("FAIL held_lo got %h want 00000006", lo); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL held_hi got %h want 0", hi); else passed++;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL held_idle got %b want 0", busy); else passed++;
  endtask

  task automatic test_rst_mid;
    issue(3'b010, 32'hFFFF_FFFF, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL rstmid_hi got %h want 0", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL rstmid_lo got %h want 0", lo); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else passed++;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu_b2b;
    test_div;
    test_div_zero;
    test_mthi_mtlo;
    test_flush;
    test_start_while_busy;
    test_rst_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Parametrised successor to the plain HI/LO register pair: holds HI/LO and executes multi-cycle multiply/divide whose results land in HI/LO.
- Sits in the EX stage of the pipelined CPU. The pipeline issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start handshake and stalls on busy.
- Supports abort when a branch or exception flushes the issuing instruction.

Parameters:
- DATA_W, 32, operand/HI/LO width; must be ≥4 and even.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted when start=1, busy=0, flush=0
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
- a  in  DATA_W  multiplicand / dividend / MTHI-MTLO data
- b  in  DATA_W  multiplier / divisor
- flush  in  1  abort in-flight op
- busy  out  1  state≠IDLE (combinational from state)
- done  out  1  one-cycle pulse when HI/LO updated by a mul/div
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, done=0, counter=0, internal accumulators=0. Applies in any state and aborts an in-flight op.
- FSM states: IDLE, CALC, FIN.
- done defaults to 0 every edge unless set below.
- MTHI/MTLO accepted in IDLE:
  - Edge T0 writes a into hi (MTHI) or lo (MTLO).
  - Stays IDLE, no busy, no done.
  - Other register unchanged.
- op none/111 with start=1: ignored, no state change.
- Mul/div acceptance at edge T0:
  - Latch operands. Signed ops take magnitudes of a and b; record result sign and remainder sign.
  - Clear counter; go to CALC.
- CALC, one radix-2 step per edge:
  - Multiply: shift-add over a 2*DATA_W product register.
  - Divide: restoring shift-subtract, quotient/remainder DATA_W each.
  - After DATA_W steps (edge T0+DATA_W), go to FIN.
- FIN at edge T0+DATA_W+1:
  - Apply sign correction.
  - Multiply: hi=product[2*DATA_W-1:DATA_W], lo=product[DATA_W-1:0].
  - Divide: lo=quotient, hi=remainder.
  - done=1 for the following cycle; state=IDLE.
- Timing: busy=1 from after edge T0 until edge T0+DATA_W+1. Total latency is DATA_W+1 edges from acceptance to hi/lo visible.
- Signed rules:
  - Product sign = a[MSB]^b[MSB].
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV of most-negative by −1: lo=most-negative, hi=0, no trap.
- Divide by zero (signed or unsigned): hi=a, lo=all ones. Same latency as a normal divide.
- hi/lo stay stable during CALC and FIN. Reads during busy return old values.
- start while busy: not accepted, ignored. The pipeline holds the request and stall logic uses busy.
- flush:
  - In CALC/FIN: next edge → IDLE, hi/lo unchanged, done=0.
  - In IDLE: blocks acceptance in the same cycle; flush wins over start.
  - flush has no effect on an MTHI/MTLO already written.
- Back-to-back: start may be accepted in the same cycle done=1 (state IDLE). The new op's T0 is that edge.
- Reset mid-operation: next edge IDLE, hi=lo=0, done=0.

Test Plan:
- MULT a=0xFFFFFFFD (−3), b=5 → after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFF1. done pulse exactly 1 cycle; busy high 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=100, b=7 issued in the done cycle → lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → hi=0x00001234, lo=0xFFFFFFFF. Repeat with DIV → identical result.
- MTHI a=0xCAFEF00D, then MTLO a=0x12345678 on consecutive edges → hi/lo updated one edge each, busy never high. Then MULT with start held plus a second start while busy → second start ignored.
- MULT started, flush at 10th CALC cycle → next edge busy=0, done never asserts, hi/lo retain 0xCAFEF00D/0x12345678. Separately, rst mid-CALC → hi=lo=0, IDLE next edge.
